// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial-adder scheduler.
// Provides the controller state encoding and the signed-overflow helper.
package serial_add_pkg;

  localparam int SA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } sa_state_t;

  // Two's-complement overflow: operands share a sign that the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_add_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above ptr,
// wrapping to the lowest request when none are found above it.
module rr_arbiter
  import serial_add_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [NREQ-1:0] w_hi;
  logic [NREQ-1:0] w_pick;

  always_comb begin
    w_hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_hi[i] = req[i] && (IDW'(i) >= ptr);
    end
    w_pick = (|w_hi) ? w_hi : req;
  end

  // Descending scan so the lowest set bit of w_pick is the last one written.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_pick[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder between NREQ requesters.
// Optional signed-overflow result output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_sched
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int NREQ  = 2,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic                  resp_ovf,
`endif
  output logic                  dp_pload,
  output logic                  dp_enable,
  output logic [WIDTH-1:0]      dp_adata,
  output logic [WIDTH-1:0]      dp_bdata,
  input  logic [WIDTH-1:0]      dp_pout,
  input  logic                  dp_cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  sa_state_t        r_state;
  sa_state_t        w_next;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_adata;
  logic [WIDTH-1:0] r_bdata;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [IDW-1:0]   r_id;
`ifdef SERIAL_ADD_OVF_EN
  logic             r_ovf;
`endif

  logic [NREQ-1:0]  w_gnt;
  logic [IDW-1:0]   w_idx;
  logic             w_any;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_last;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req(req),
    .ptr(r_ptr),
    .gnt(w_gnt),
    .idx(w_idx),
    .any(w_any)
  );

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = LOAD;
      LOAD:    w_next = SHIFT;
      SHIFT:   if (w_last) w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode; a grant raised while rst is high would never be honoured.
  always_comb begin
    gnt        = '0;
    dp_pload   = 1'b0;
    dp_enable  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      IDLE:    if (!rst) gnt = w_gnt;
      LOAD:    dp_pload = 1'b1;
      SHIFT:   dp_enable = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, bit counter and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_adata <= '0;
      r_bdata <= '0;
      r_id    <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_adata <= w_a;
            r_bdata <= w_b;
            r_id    <= w_idx;
            r_ptr   <= w_ptr_nxt;
          end
        end
        LOAD: r_cnt <= '0;
        SHIFT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_cout <= dp_cout;
        end
        CAPTURE: begin
          r_sum <= dp_pout;
`ifdef SERIAL_ADD_OVF_EN
          r_ovf <= add_ovf(r_adata[WIDTH-1], r_bdata[WIDTH-1], dp_pout[WIDTH-1]);
`endif
        end
        default: ;
      endcase
    end
  end

  assign dp_adata  = r_adata;
  assign dp_bdata  = r_bdata;
  assign resp_id   = r_id;
  assign resp_sum  = r_sum;
  assign resp_cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign resp_ovf  = r_ovf;
`endif

  ap_pload_enable_excl: assert property (@(posedge clk) disable iff (rst)
    !(dp_pload && dp_enable));
  ap_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched with a behavioural LSB-first serial adder
// standing in for the shared datapath.
module tb_serial_add_sched;

  localparam int W    = 8;
  localparam int NREQ = 2;
  localparam int IDW  = 3;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0] gnt;
  logic            resp_valid;
  logic            resp_ready;
  logic [IDW-1:0]  resp_id;
  logic [W-1:0]    resp_sum;
  logic            resp_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic            resp_ovf;
`endif
  logic            dp_pload;
  logic            dp_enable;
  logic [W-1:0]    dp_adata;
  logic [W-1:0]    dp_bdata;
  logic [W-1:0]    dp_pout;
  logic            dp_cout;

  int n_vec = 0;
  int n_err = 0;

  serial_add_sched #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .gnt       (gnt),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout),
`ifdef SERIAL_ADD_OVF_EN
    .resp_ovf  (resp_ovf),
`endif
    .dp_pload  (dp_pload),
    .dp_enable (dp_enable),
    .dp_adata  (dp_adata),
    .dp_bdata  (dp_bdata),
    .dp_pout   (dp_pout),
    .dp_cout   (dp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial adder: one bit per enable, carry cleared only by pload.
  logic [W-1:0] m_a, m_b, m_p;
  logic         m_c;
  logic         m_s;
  assign m_s     = m_a[0] ^ m_b[0] ^ m_c;
  assign dp_cout = (m_a[0] & m_b[0]) | (m_a[0] & m_c) | (m_b[0] & m_c);
  assign dp_pout = m_p;

  always @(posedge clk) begin
    if (dp_pload) begin
      m_a <= dp_adata;
      m_b <= dp_bdata;
      m_c <= 1'b0;
      m_p <= '0;
    end else if (dp_enable) begin
      m_a <= m_a >> 1;
      m_b <= m_b >> 1;
      m_c <= dp_cout;
      m_p <= {m_s, m_p[W-1:1]};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_gnt(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 60; i++) begin
      if (gnt !== '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  // Starts in the grant cycle; drives req_after on the next cycle and runs to resp_valid.
  task automatic wait_valid(input logic [NREQ-1:0] req_after, output int lat, output int npl,
                            output int nen, output int ngnt, output bit ok);
    lat  = 0;
    npl  = 0;
    nen  = 0;
    ngnt = 0;
    ok   = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) req = req_after;
      #1;
      lat++;
      if (dp_pload === 1'b1) npl++;
      if (dp_enable === 1'b1) nen++;
      if (gnt !== '0) ngnt++;
      if (resp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({gnt, dp_pload, dp_enable, resp_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 00000", {gnt, dp_pload, dp_enable, resp_valid});
    end
    n_vec++;
    if ({resp_id, resp_sum, resp_cout, dp_adata, dp_bdata} !== '0) begin
      n_err++;
      $display("FAIL reset_data: id=%0d sum=%h cout=%b a=%h b=%h required all 0",
               resp_id, resp_sum, resp_cout, dp_adata, dp_bdata);
    end
  endtask

  // One full operation from requester id with the response accepted immediately.
  task automatic single_op(input string nm, input int id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
    int cyc, lat, npl, nen, ngnt;
    bit ok;
    logic [NREQ-1:0] exp_gnt;
    exp_gnt = '0;
    exp_gnt[id] = 1'b1;
    @(negedge clk);
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    req = exp_gnt;
    #1;
    wait_gnt(cyc, ok);
    n_vec++;
    if (!ok || gnt !== exp_gnt || cyc != 0) begin
      n_err++;
      $display("FAIL %s_gnt: got %b after %0d cycles, required %b immediately", nm, gnt, cyc, exp_gnt);
    end
    wait_valid('0, lat, npl, nen, ngnt, ok);
    n_vec++;
    if (!ok || lat != W + 3 || npl != 1 || nen != W) begin
      n_err++;
      $display("FAIL %s_seq: latency %0d pload %0d enable %0d, required %0d/1/%0d",
               nm, lat, npl, nen, W + 3, W);
    end
    n_vec++;
    if (resp_sum !== exp_sum || resp_cout !== exp_cout || resp_id !== IDW'(id)) begin
      n_err++;
      $display("FAIL %s_resp: sum=%h cout=%b id=%0d, required sum=%h cout=%b id=%0d",
               nm, resp_sum, resp_cout, resp_id, exp_sum, exp_cout, id);
    end
`ifdef SERIAL_ADD_OVF_EN
    n_vec++;
    if (resp_ovf !== exp_ovf) begin
      n_err++;
      $display("FAIL %s_ovf: got %b required %b", nm, resp_ovf, exp_ovf);
    end
`else
    if (exp_ovf === 1'bx) $display("note: unexpected ovf argument");
`endif
    handshake();
    n_vec++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drop: resp_valid=%b after handshake, required 0", nm, resp_valid);
    end
  endtask

  task automatic test_single();
    single_op("single", 0, 8'h3C, 8'h42, 8'h7E, 1'b0, 1'b0);
  endtask

  task automatic test_carry();
    single_op("carry", 0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    single_op("ovf", 1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
`endif
  endtask

  task automatic test_contention();
    int cyc, lat, npl, nen, ngnt;
    bit ok;
    logic [NREQ-1:0] exp_gnt;
    logic [W-1:0]    exp_sum;
    logic            exp_cout;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_a = {8'hF0, 8'h10};
    req_b = {8'h35, 8'h20};
    resp_ready = 1'b1;
    req = 2'b11;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_sum  = (k % 2 == 0) ? 8'h30 : 8'h25;
      exp_cout = (k % 2 == 0) ? 1'b0 : 1'b1;
      wait_gnt(cyc, ok);
      n_vec++;
      if (!ok || gnt !== exp_gnt || cyc != ((k == 0) ? 0 : 1)) begin
        n_err++;
        $display("FAIL contention_gnt%0d: got %b after %0d cycles, required %b after %0d",
                 k, gnt, cyc, exp_gnt, (k == 0) ? 0 : 1);
      end
      wait_valid(2'b11, lat, npl, nen, ngnt, ok);
      n_vec++;
      if (!ok || lat != W + 3 || ngnt != 0) begin
        n_err++;
        $display("FAIL contention_lat%0d: latency %0d extra grants %0d, required %0d/0",
                 k, lat, ngnt, W + 3);
      end
      n_vec++;
      if (resp_id !== IDW'(k % 2) || resp_sum !== exp_sum || resp_cout !== exp_cout) begin
        n_err++;
        $display("FAIL contention_resp%0d: id=%0d sum=%h cout=%b, required id=%0d sum=%h cout=%b",
                 k, resp_id, resp_sum, resp_cout, k % 2, exp_sum, exp_cout);
      end
    end
    req = '0;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    n_vec++;
    if (resp_valid !== 1'b0 || gnt !== '0) begin
      n_err++;
      $display("FAIL contention_end: valid=%b gnt=%b, required 0/00", resp_valid, gnt);
    end
  endtask

  task automatic test_backpressure();
    int cyc, lat, npl, nen, ngnt;
    bit ok;
    @(negedge clk);
    req_a = {8'h81, 8'h55};
    req_b = {8'h81, 8'h0A};
    req = 2'b01;
    #1;
    wait_gnt(cyc, ok);
    n_vec++;
    if (!ok || gnt !== 2'b01) begin
      n_err++;
      $display("FAIL bp_gnt0: got %b required 01", gnt);
    end
    wait_valid(2'b10, lat, npl, nen, ngnt, ok);
    n_vec++;
    if (!ok || lat != W + 3 || ngnt != 0) begin
      n_err++;
      $display("FAIL bp_lat: latency %0d grants %0d, required %0d/0", lat, ngnt, W + 3);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({resp_valid, resp_id, resp_sum, resp_cout, gnt} !== {1'b1, 3'd0, 8'h5F, 1'b0, 2'b00}) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d sum=%h cout=%b gnt=%b, required 1/0/5f/0/00",
                 i, resp_valid, resp_id, resp_sum, resp_cout, gnt);
      end
    end
    handshake();
    n_vec++;
    if (resp_valid !== 1'b0 || gnt !== 2'b10) begin
      n_err++;
      $display("FAIL bp_regrant: valid=%b gnt=%b, required 0/10", resp_valid, gnt);
    end
    wait_valid('0, lat, npl, nen, ngnt, ok);
    n_vec++;
    if (!ok || resp_id !== 3'd1 || resp_sum !== 8'h02 || resp_cout !== 1'b1) begin
      n_err++;
      $display("FAIL bp_resp1: id=%0d sum=%h cout=%b, required 1/02/1", resp_id, resp_sum, resp_cout);
    end
    handshake();
  endtask

  task automatic test_reset_mid_shift();
    int cyc, lat, npl, nen, ngnt, nvalid;
    bit ok;
    @(negedge clk);
    req_a = {8'hFF, 8'h00};
    req_b = {8'hFF, 8'h01};
    req = 2'b10;
    #1;
    wait_gnt(cyc, ok);
    n_vec++;
    if (!ok || gnt !== 2'b10) begin
      n_err++;
      $display("FAIL rst_gnt: got %b required 10", gnt);
    end
    @(negedge clk);
    req = '0;
    #1;
    n_vec++;
    if (dp_pload !== 1'b1) begin
      n_err++;
      $display("FAIL rst_load: dp_pload=%b required 1", dp_pload);
    end
    repeat (5) @(negedge clk);
    #1;
    n_vec++;
    if (dp_enable !== 1'b1) begin
      n_err++;
      $display("FAIL rst_shift4: dp_enable=%b required 1", dp_enable);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({gnt, dp_pload, dp_enable, resp_valid, resp_id, resp_sum, resp_cout, dp_adata, dp_bdata} !== '0) begin
      n_err++;
      $display("FAIL rst_clear: gnt=%b pl=%b en=%b v=%b id=%0d sum=%h c=%b a=%h b=%h required all 0",
               gnt, dp_pload, dp_enable, resp_valid, resp_id, resp_sum, resp_cout, dp_adata, dp_bdata);
    end
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      #1;
      if (resp_valid !== 1'b0) nvalid++;
    end
    n_vec++;
    if (nvalid != 0) begin
      n_err++;
      $display("FAIL rst_noresp: resp_valid seen %0d cycles, required 0", nvalid);
    end
    single_op("after_rst", 0, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0);
  endtask

  task automatic test_idle();
    @(negedge clk);
    req = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if ({gnt, dp_pload, dp_enable, resp_valid} !== 5'b0) begin
        n_err++;
        $display("FAIL idle%0d: gnt/pload/enable/valid=%b required 00000",
                 i, {gnt, dp_pload, dp_enable, resp_valid});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_backpressure();
    test_reset_mid_shift();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_sched.md
Name: serial_add_sched

Overview:
- Controller/arbiter that shares one 1-bit-per-cycle serial adder datapath between NREQ requesters.
- Arbitrates round-robin and latches the winner's operands.
- Sequences the datapath: one parallel-load cycle, then WIDTH shift-enable cycles.
- Captures the sum and carry-out, and returns them to the requester over a valid/ready response channel.

Parameters:
- WIDTH, 8, operand/result width; must match datapath width; >=2.
- NREQ, 2, number of requesters; 2..8.
- IDW, 3, width of requester index fields; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high with operands stable until granted
- req_a  in  NREQ*WIDTH  requester i operand A at bits [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  requester i operand B, same packing
- gnt  out  NREQ  one-hot grant; single-cycle pulse
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  IDW  index of requester owning the result
- resp_sum  out  WIDTH  A+B mod 2**WIDTH
- resp_cout  out  1  carry out of MSB
- dp_pload  out  1  datapath parallel load; also clears datapath carry
- dp_enable  out  1  datapath shift/add enable
- dp_adata  out  WIDTH  operand A to datapath
- dp_bdata  out  WIDTH  operand B to datapath
- dp_pout  in  WIDTH  datapath result register
- dp_cout  in  1  datapath combinational carry out of current bit

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; bit counter 0.
- Reset behaviour:
  - rst has priority over every other event.
  - rst in any state returns to IDLE the next cycle and discards the operation in flight; no response is issued for it.
  - dp_pload and dp_enable drop to 0 on that edge.
- State IDLE:
  - If any req bit is set, grant the first set bit at or after the pointer, searching upward with wrap.
  - Assert gnt for one cycle.
  - Latch req_a/req_b of the winner into dp_adata/dp_bdata and its index into resp_id.
  - Set pointer = winner+1, wrapping to 0 at NREQ.
  - Go to LOAD.
- State LOAD (1 cycle): dp_pload=1, dp_enable=0. Go to SHIFT with counter=0.
- State SHIFT (exactly WIDTH cycles):
  - dp_enable=1.
  - Counter increments each cycle.
  - In the cycle with counter==WIDTH-1, register dp_cout into resp_cout, then go to CAPTURE.
- State CAPTURE (1 cycle):
  - dp_enable=0.
  - Register dp_pout into resp_sum.
  - Go to RESP.
- State RESP:
  - resp_valid=1.
  - resp_id, resp_sum and resp_cout are held stable until handshake.
  - On resp_valid && resp_ready, go to IDLE, with resp_valid=0 from the next cycle.
- Latency: gnt pulse to first resp_valid = WIDTH+3 cycles (IDLE→LOAD→SHIFT×WIDTH→CAPTURE→RESP).
- Throughput: at most one operation per WIDTH+4 cycles when resp_ready is held high.
- No new grant is issued while not in IDLE; pending req bits simply wait.
- A requester deasserting req before grant is legal. It is ignored because arbitration samples req only in IDLE.
- dp_adata/dp_bdata are held constant from grant until the next grant.
- The datapath must be told to clear carry only via dp_pload; the controller never asserts dp_pload and dp_enable together.
- Counter width: clog2(WIDTH)+1 bits; no wrap-around inside one operation.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- When defined:
  - Extra output resp_ovf (1 bit), reset 0, valid and held under the same rules as resp_sum.
  - resp_ovf = signed two's-complement overflow = (a_msb == b_msb) && (sum_msb != a_msb), using the latched operands and the captured sum.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package serial_add_pkg:
  - State enum: IDLE, LOAD, SHIFT, CAPTURE, RESP; 3-bit encoding.
  - Default-width constant SA_WIDTH=8.
- One natural sub-module, rr_arbiter:
  - Inputs: req and pointer.
  - Outputs: one-hot grant and encoded index.
  - Combinational, parameterised by NREQ.
- Datapath instantiation stays at the parent level and is not inside this block.

Test Plan:
- Single add: req[0] with A=0x3C, B=0x42 → gnt=01; dp_pload for 1 cycle; dp_enable for 8 cycles; resp_valid 11 cycles after gnt; resp_sum=0x7E, resp_cout=0, resp_id=0.
- Carry out: A=0xFF, B=0x01 → resp_sum=0x00, resp_cout=1; with SERIAL_ADD_OVF_EN, A=0x7F, B=0x01 → sum=0x80, ovf=1, cout=0.
- Contention: req=11 held continuously with distinct operands, pointer 0 → grants alternate 01, 10, 01; each resp_id matches its operands' sum.
- Backpressure: resp_ready=0 for 5 cycles in RESP → resp_valid and data stable; no gnt while req[1] pending; grant follows one cycle after the handshake.
- Reset mid-SHIFT: rst asserted at shift cycle 4 → next cycle all outputs 0, state IDLE; no resp_valid; next request completes correctly from a clean carry.
- Idle: req=00 for 20 cycles → gnt, dp_pload, dp_enable and resp_valid remain 0.
